// File: rtl/lsu_arbiter.sv
// Two-port arbiter (instruction fetch, data) in front of a single LSU.
// Operands are latched at grant time so the LSU sees stable commands until lsu_done.
module lsu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [7:0]  f_addr,
  output logic        f_done,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic [1:0]  lsu_en_ls,
  output logic [7:0]  lsu_address,
  output logic [15:0] lsu_data_to_store,
  input  logic        lsu_done,
  input  logic [15:0] lsu_data_to_load,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_reg, state_next;
  logic   grant_reg;
  logic   last_grant_reg;
  logic   we_reg;
  logic   pick_data;

  // Data wins when it is the only requester, on any tie in fixed-priority
  // mode, or on a tie in round-robin mode when fetch was served last.
  always_comb begin
    pick_data = d_req && (!f_req || !RR_EN || !last_grant_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (f_req || d_req) state_next = WAIT;
      WAIT:    if (lsu_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE);
    f_done = (state_reg == RESP) && !grant_reg;
    d_done = (state_reg == RESP) && grant_reg;
    grant  = grant_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_reg         <= 1'b0;
      last_grant_reg    <= 1'b1;
      we_reg            <= 1'b0;
      lsu_en_ls         <= 2'b00;
      lsu_address       <= 8'h00;
      lsu_data_to_store <= 16'h0000;
      f_rdata           <= 16'h0000;
      d_rdata           <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (f_req || d_req) begin
            grant_reg         <= pick_data;
            last_grant_reg    <= pick_data;
            we_reg            <= pick_data && d_we;
            lsu_address       <= pick_data ? d_addr : f_addr;
            lsu_data_to_store <= pick_data ? d_wdata : 16'h0000;
            lsu_en_ls         <= (pick_data && d_we) ? 2'b10 : 2'b01;
          end
        end
        WAIT: begin
          if (lsu_done) begin
            // Drop the command on the completion edge so the LSU cannot restart.
            lsu_en_ls <= 2'b00;
            if (!we_reg) begin
              if (grant_reg) d_rdata <= lsu_data_to_load;
              else           f_rdata <= lsu_data_to_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: a round-robin instance and a fixed-priority instance.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we, lsu_done;
  logic        f_req0, d_req0, lsu_done0;
  logic [7:0]  f_addr, d_addr;
  logic [15:0] d_wdata, lsu_data_to_load;

  logic        f_done, d_done, busy, grant;
  logic [15:0] f_rdata, d_rdata, lsu_data_to_store;
  logic [1:0]  lsu_en_ls;
  logic [7:0]  lsu_address;

  logic        f_done0, d_done0, busy0, grant0;
  logic [15:0] f_rdata0, d_rdata0, lsu_data_to_store0;
  logic [1:0]  lsu_en_ls0;
  logic [7:0]  lsu_address0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .lsu_en_ls(lsu_en_ls), .lsu_address(lsu_address),
    .lsu_data_to_store(lsu_data_to_store), .lsu_done(lsu_done),
    .lsu_data_to_load(lsu_data_to_load), .busy(busy), .grant(grant)
  );

  lsu_arbiter #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .f_req(f_req0), .f_addr(f_addr), .f_done(f_done0), .f_rdata(f_rdata0),
    .d_req(d_req0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done0), .d_rdata(d_rdata0),
    .lsu_en_ls(lsu_en_ls0), .lsu_address(lsu_address0),
    .lsu_data_to_store(lsu_data_to_store0), .lsu_done(lsu_done0),
    .lsu_data_to_load(lsu_data_to_load), .busy(busy0), .grant(grant0)
  );

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (lsu_en_ls !== 2'b00) begin bad++; $display("FAIL reset_en got=%b exp=00", lsu_en_ls); end
    total++; if (lsu_address !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", lsu_address); end
    total++; if (lsu_data_to_store !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", lsu_data_to_store); end
    total++; if ({f_done, d_done, grant} !== 3'b000) begin bad++; $display("FAIL reset_done_grant got=%b exp=000", {f_done, d_done, grant}); end
    total++; if ({f_rdata, d_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", {f_rdata, d_rdata}); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_fetch_load();
    f_req = 1'b1;
    f_addr = 8'h12;
    cyc();
    total++; if (lsu_en_ls !== 2'b01) begin bad++; $display("FAIL fetch_en got=%b exp=01", lsu_en_ls); end
    total++; if (lsu_address !== 8'h12) begin bad++; $display("FAIL fetch_addr got=%h exp=12", lsu_address); end
    total++; if ({busy, grant} !== 2'b10) begin bad++; $display("FAIL fetch_busy_grant got=%b exp=10", {busy, grant}); end
    f_addr = 8'h99;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if ({lsu_en_ls, lsu_address} !== {2'b01, 8'h12}) begin bad++; $display("FAIL fetch_wait_hold cyc=%0d got=%b/%h exp=01/12", i, lsu_en_ls, lsu_address); end
    end
    lsu_done = 1'b1;
    lsu_data_to_load = 16'hBEEF;
    cyc();
    lsu_done = 1'b0;
    total++; if ({f_done, d_done} !== 2'b10) begin bad++; $display("FAIL fetch_done got=%b exp=10", {f_done, d_done}); end
    total++; if (lsu_en_ls !== 2'b00) begin bad++; $display("FAIL fetch_resp_en got=%b exp=00", lsu_en_ls); end
    total++; if (f_rdata !== 16'hBEEF) begin bad++; $display("FAIL fetch_rdata got=%h exp=beef", f_rdata); end
    f_req = 1'b0;
    cyc();
    total++; if ({f_done, busy, lsu_en_ls} !== 4'b0000) begin bad++; $display("FAIL fetch_idle got=%b exp=0000", {f_done, busy, lsu_en_ls}); end
    $display("fetch load addr=12 rdata=%h", f_rdata);
  endtask

  task automatic test_operand_change();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 8'h40;
    cyc();
    total++; if ({lsu_en_ls, lsu_address, grant} !== {2'b01, 8'h40, 1'b1}) begin bad++; $display("FAIL dload_cmd got=%b/%h/%b exp=01/40/1", lsu_en_ls, lsu_address, grant); end
    d_addr = 8'h41;
    d_wdata = 16'hFFFF;
    cyc();
    total++; if (lsu_address !== 8'h40) begin bad++; $display("FAIL opchange_addr got=%h exp=40", lsu_address); end
    lsu_done = 1'b1;
    lsu_data_to_load = 16'h1234;
    cyc();
    lsu_done = 1'b0;
    total++; if ({d_done, f_done} !== 2'b10) begin bad++; $display("FAIL dload_done got=%b exp=10", {d_done, f_done}); end
    total++; if ({d_rdata, f_rdata} !== {16'h1234, 16'hBEEF}) begin bad++; $display("FAIL dload_rdata got=%h/%h exp=1234/beef", d_rdata, f_rdata); end
    d_req = 1'b0;
    cyc();
    total++; if (d_done !== 1'b0) begin bad++; $display("FAIL dload_done_pulse got=%b exp=0", d_done); end
    $display("data load addr=40 rdata=%h", d_rdata);
  endtask

  task automatic test_store();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 8'h40;
    d_wdata = 16'hA55A;
    cyc();
    total++; if ({lsu_en_ls, lsu_address, lsu_data_to_store} !== {2'b10, 8'h40, 16'hA55A}) begin bad++; $display("FAIL store_cmd got=%b/%h/%h exp=10/40/a55a", lsu_en_ls, lsu_address, lsu_data_to_store); end
    lsu_done = 1'b1;
    lsu_data_to_load = 16'h7777;
    cyc();
    total++; if ({d_done, f_done, lsu_en_ls} !== 4'b1000) begin bad++; $display("FAIL store_done got=%b exp=1000", {d_done, f_done, lsu_en_ls}); end
    total++; if (d_rdata !== 16'h1234) begin bad++; $display("FAIL store_rdata got=%h exp=1234", d_rdata); end
    d_req = 1'b0;
    cyc();
    lsu_done = 1'b0;
    total++; if ({d_done, busy, grant, lsu_en_ls} !== 5'b00100) begin bad++; $display("FAIL store_idle got=%b exp=00100", {d_done, busy, grant, lsu_en_ls}); end
    d_we = 1'b0;
    $display("data store addr=40 wdata=a55a d_rdata=%h", d_rdata);
  endtask

  task automatic test_tie_rr();
    reset = 1'b1;
    f_req = 1'b1;
    d_req = 1'b1;
    f_addr = 8'h20;
    d_addr = 8'h30;
    cyc();
    reset = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      exp_g = k[0];
      total++; if ({busy, grant, lsu_address} !== {1'b1, exp_g, exp_g ? 8'h30 : 8'h20}) begin bad++; $display("FAIL rr_grant k=%0d got=%b/%b/%h exp=1/%b", k, busy, grant, lsu_address, exp_g); end
      lsu_done = 1'b1;
      cyc();
      lsu_done = 1'b0;
      total++; if ({f_done, d_done} !== {~exp_g, exp_g}) begin bad++; $display("FAIL rr_done k=%0d got=%b exp=%b", k, {f_done, d_done}, {~exp_g, exp_g}); end
      cyc();
      total++; if ({busy, lsu_en_ls} !== 3'b000) begin bad++; $display("FAIL rr_gap k=%0d got=%b exp=000", k, {busy, lsu_en_ls}); end
      cyc();
      $display("rr tie transaction %0d grant=%b", k, grant);
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_tie_fixed();
    reset = 1'b1;
    f_req0 = 1'b1;
    d_req0 = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      logic exp_g;
      exp_g = (k < 2);
      total++; if ({busy0, grant0} !== {1'b1, exp_g}) begin bad++; $display("FAIL fixed_grant k=%0d got=%b exp=1%b", k, {busy0, grant0}, exp_g); end
      lsu_done0 = 1'b1;
      cyc();
      lsu_done0 = 1'b0;
      total++; if ({f_done0, d_done0} !== {~exp_g, exp_g}) begin bad++; $display("FAIL fixed_done k=%0d got=%b exp=%b", k, {f_done0, d_done0}, {~exp_g, exp_g}); end
      if (k == 1) d_req0 = 1'b0;
      if (k == 2) f_req0 = 1'b0;
      cyc();
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL fixed_gap k=%0d got=%b exp=0", k, busy0); end
      cyc();
      $display("fixed tie transaction %0d grant=%b", k, grant0);
    end
  endtask

  task automatic test_reset_mid_wait();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 8'h55;
    cyc();
    total++; if ({busy, grant} !== 2'b11) begin bad++; $display("FAIL rst_wait_start got=%b exp=11", {busy, grant}); end
    cyc();
    reset = 1'b1;
    d_req = 1'b0;
    cyc();
    reset = 1'b0;
    total++; if ({busy, lsu_en_ls, f_done, d_done, grant} !== 6'b000000) begin bad++; $display("FAIL rst_wait got=%b exp=000000", {busy, lsu_en_ls, f_done, d_done, grant}); end
    total++; if (lsu_address !== 8'h00) begin bad++; $display("FAIL rst_wait_addr got=%h exp=00", lsu_address); end
    lsu_done = 1'b1;
    lsu_data_to_load = 16'hDEAD;
    cyc();
    lsu_done = 1'b0;
    total++; if ({busy, f_done, d_done, lsu_en_ls} !== 5'b00000) begin bad++; $display("FAIL stray_done got=%b exp=00000", {busy, f_done, d_done, lsu_en_ls}); end
    total++; if ({f_rdata, d_rdata} !== 32'h0) begin bad++; $display("FAIL stray_rdata got=%h exp=00000000", {f_rdata, d_rdata}); end
    cyc();
    total++; if ({busy, f_done, d_done} !== 3'b000) begin bad++; $display("FAIL stray_after got=%b exp=000", {busy, f_done, d_done}); end
    $display("reset mid-wait and stray lsu_done handled");
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; lsu_done = 1'b0;
    f_req0 = 1'b0; d_req0 = 1'b0; lsu_done0 = 1'b0;
    f_addr = 8'h00; d_addr = 8'h00; d_wdata = 16'h0; lsu_data_to_load = 16'h0;
    @(negedge clk);
    test_reset();
    test_fetch_load();
    test_operand_change();
    test_store();
    test_tie_rr();
    test_tie_fixed();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
